// File: rtl/aggr_stream.sv
// Streaming graph aggregation: accumulates N_NODES input node vectors per frame
// over a programmable adjacency (saturating sum or max), then drains one aggregate per node.
module aggr_stream #(
    parameter int N_NODES       = 4,
    parameter int N_FEAT        = 4,
    parameter int AGGR_IN_SIZE  = 5,
    parameter int AGGR_OUT_SIZE = 7,
    parameter logic [N_NODES*N_NODES-1:0] ADJ_INIT = 16'hEDB7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_FEAT*AGGR_IN_SIZE-1:0]    in_feat,
    input  logic                              mode,
    input  logic                              adj_we,
    input  logic [$clog2(N_NODES)-1:0]        adj_row,
    input  logic [N_NODES-1:0]                adj_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_FEAT*AGGR_OUT_SIZE-1:0]   out_feat,
    output logic [$clog2(N_NODES)-1:0]        out_node,
    output logic                              out_last
);

    localparam int NW = $clog2(N_NODES);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [NW-1:0] LAST_NODE = NW'(N_NODES - 1);
    localparam logic signed [AGGR_OUT_SIZE-1:0] ACC_MAX = {1'b0, {(AGGR_OUT_SIZE-1){1'b1}}};
    localparam logic signed [AGGR_OUT_SIZE-1:0] ACC_MIN = {1'b1, {(AGGR_OUT_SIZE-1){1'b0}}};

    logic [0:0]                      state;
    logic [NW-1:0]                   node_cnt;
    logic [NW-1:0]                   out_node_q;
    logic                            mode_q;
    logic [N_NODES-1:0]              adj [N_NODES];
    logic [N_NODES-1:0]              touched;
    logic signed [AGGR_OUT_SIZE-1:0] acc     [N_NODES][N_FEAT];
    logic signed [AGGR_OUT_SIZE-1:0] acc_upd [N_NODES][N_FEAT];
    logic signed [AGGR_OUT_SIZE-1:0] x_ext   [N_FEAT];
    logic [N_NODES-1:0]              hit;
    logic                            beat;
    logic                            mode_eff;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    function automatic logic signed [AGGR_OUT_SIZE-1:0] sat_add(
        input logic signed [AGGR_OUT_SIZE-1:0] a,
        input logic signed [AGGR_OUT_SIZE-1:0] b
    );
        logic [AGGR_OUT_SIZE:0] s;
        s = {a[AGGR_OUT_SIZE-1], a} + {b[AGGR_OUT_SIZE-1], b};
        if (s[AGGR_OUT_SIZE] != s[AGGR_OUT_SIZE-1])
            return s[AGGR_OUT_SIZE] ? ACC_MIN : ACC_MAX;
        return s[AGGR_OUT_SIZE-1:0];
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign out_node  = out_node_q;
    assign out_last  = out_valid && (out_node_q == LAST_NODE);
    assign beat      = in_valid && in_ready;
    // The first beat of a frame already runs under the freshly presented mode.
    assign mode_eff  = (node_cnt == '0) ? mode : mode_q;

    // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
    always_comb begin
        for (int f = 0; f < N_FEAT; f++)
            x_ext[f] = AGGR_OUT_SIZE'($signed(in_feat[f*AGGR_IN_SIZE +: AGGR_IN_SIZE]));
        for (int i = 0; i < N_NODES; i++) begin
            hit[i] = beat && adj[i][node_cnt];
            for (int f = 0; f < N_FEAT; f++) begin
                if (mode_eff)
                    acc_upd[i][f] = (touched[i] && (acc[i][f] > x_ext[f])) ? acc[i][f] : x_ext[f];
                else
                    acc_upd[i][f] = sat_add(acc[i][f], x_ext[f]);
            end
        end
    end

    // NOTE: the accumulator array is reset explicitly because a mid-frame reset must discard partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            node_cnt   <= '0;
            out_node_q <= '0;
            mode_q     <= 1'b0;
            touched    <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                adj[i] <= ADJ_INIT[i*N_NODES +: N_NODES];
                for (int f = 0; f < N_FEAT; f++)
                    acc[i][f] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    // Writes land after this edge, so a concurrent beat still sees the old row.
                    if (adj_we && (node_cnt == '0))
                        adj[adj_row] <= adj_data;
                    if (beat) begin
                        if (node_cnt == '0)
                            mode_q <= mode;
                        for (int i = 0; i < N_NODES; i++) begin
                            if (hit[i]) begin
                                touched[i] <= 1'b1;
                                for (int f = 0; f < N_FEAT; f++)
                                    acc[i][f] <= acc_upd[i][f];
                            end
                        end
                        if (node_cnt == LAST_NODE) begin
                            node_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            node_cnt <= node_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_node_q == LAST_NODE) begin
                            state      <= ACCUM;
                            out_node_q <= '0;
                            touched    <= '0;
                            for (int i = 0; i < N_NODES; i++)
                                for (int f = 0; f < N_FEAT; f++)
                                    acc[i][f] <= '0;
                        end else begin
                            out_node_q <= out_node_q + 1'b1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // NOTE: out_feat gets a default before the conditional so no latch is inferred.
    always_comb begin
        out_feat = '0;
        if (state == DRAIN)
            for (int f = 0; f < N_FEAT; f++)
                out_feat[f*AGGR_OUT_SIZE +: AGGR_OUT_SIZE] = acc[out_node_q][f];
    end

endmodule
